// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves RV32-style control transfers (JAL, JALR, conditional
//               branches) one instruction per cycle. A taken, word-aligned
//               transfer redirects fetch and squashes the single wrong-path
//               instruction that follows it. JAL/JALR also request a link
//               write. Misaligned targets raise a one-cycle exception pulse
//               instead of redirecting.
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               instr_in, pc_in   - instruction and its PC from fetch
//               instr_valid       - qualifies instr_in/pc_in
//               rs1_val, rs2_val  - source operand values
//               was_branch        - redirect request to fetch
//               branch_result     - redirect target
//               squash            - instruction presented this cycle is
//                                   wrong-path
//               link_valid        - link register write request
//               link_data         - link value (pc + 4)
//               rd_addr           - link destination register
//               misalign_exc      - misaligned-target exception pulse
//               branch_count      - resolved conditional branches (saturating)
//               taken_count       - redirects issued (saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            was_branch,
    output logic [XLEN-1:0] branch_result,
    output logic            squash,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic [4:0]      rd_addr,
    output logic            misalign_exc,
    output logic [15:0]     branch_count,
    output logic [15:0]     taken_count
);

    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_was_branch;
    logic [XLEN-1:0] r_branch_result;
    logic            r_squash;
    logic            r_link_valid;
    logic [XLEN-1:0] r_link_data;
    logic [4:0]      r_rd_addr;
    logic            r_misalign_exc;
    logic [15:0]     r_branch_count;
    logic [15:0]     r_taken_count;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_branch;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_cond;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_accept;

    assign w_opcode    = instr_in[6:0];
    assign w_funct3    = instr_in[14:12];
    assign w_rd        = instr_in[11:7];

    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_is_jalr   = (w_opcode == c_OP_JALR) && (w_funct3 == 3'b000);
    // funct3 010/011 are unused branch encodings and fall through as non-control
    assign w_is_branch = (w_opcode == c_OP_BRANCH) && (w_funct3[2:1] != 2'b01);

    assign w_imm_j = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                      instr_in[20], instr_in[30:21], 1'b0};
    assign w_imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign w_imm_b = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                      instr_in[30:25], instr_in[11:8], 1'b0};

    assign w_jalr_sum = rs1_val + w_imm_i;
    assign w_pc_plus4 = pc_in + XLEN'(4);

    always_comb begin
        w_cond = 1'b0;
        case (w_funct3)
            3'b000:  w_cond = (rs1_val == rs2_val);
            3'b001:  w_cond = (rs1_val != rs2_val);
            3'b100:  w_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  w_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  w_cond = (rs1_val <  rs2_val);
            3'b111:  w_cond = (rs1_val >= rs2_val);
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_target = pc_in + w_imm_b;
        if (w_is_jal) begin
            w_target = pc_in + w_imm_j;
        end else if (w_is_jalr) begin
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    // The squash cycle swallows whatever is presented, valid or not.
    assign w_accept = instr_valid && (r_state == ST_IDLE);
    assign w_taken  = w_is_jal || w_is_jalr || (w_is_branch && w_cond);

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_was_branch    <= 1'b0;
            r_branch_result <= '0;
            r_squash        <= 1'b0;
            r_link_valid    <= 1'b0;
            r_link_data     <= '0;
            r_rd_addr       <= '0;
            r_misalign_exc  <= 1'b0;
            r_branch_count  <= '0;
            r_taken_count   <= '0;
        end else begin
            // Pulse outputs default low; target/link values hold.
            r_was_branch   <= 1'b0;
            r_squash       <= 1'b0;
            r_link_valid   <= 1'b0;
            r_misalign_exc <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_branch && (r_branch_count != c_CNT_MAX)) begin
                            r_branch_count <= r_branch_count + 16'd1;
                        end
                        if (w_taken) begin
                            if (w_target[1:0] != 2'b00) begin
                                r_misalign_exc <= 1'b1;
                            end else begin
                                r_was_branch    <= 1'b1;
                                r_branch_result <= w_target;
                                r_squash        <= 1'b1;
                                r_state         <= ST_SQUASH;
                                if (r_taken_count != c_CNT_MAX) begin
                                    r_taken_count <= r_taken_count + 16'd1;
                                end
                                // Writes to x0 are discarded, so no link request.
                                if ((w_is_jal || w_is_jalr) && (w_rd != 5'd0)) begin
                                    r_link_valid <= 1'b1;
                                    r_link_data  <= w_pc_plus4;
                                    r_rd_addr    <= w_rd;
                                end
                            end
                        end
                    end
                end
                ST_SQUASH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign was_branch    = r_was_branch;
    assign branch_result = r_branch_result;
    assign squash        = r_squash;
    assign link_valid    = r_link_valid;
    assign link_data     = r_link_data;
    assign rd_addr       = r_rd_addr;
    assign misalign_exc  = r_misalign_exc;
    assign branch_count  = r_branch_count;
    assign taken_count   = r_taken_count;

endmodule
`default_nettype wire
